// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad row emulator and the keypad decoder:
// FSM state encoding, key-code field positions, idle row pattern, clock rate.
package keypad_pkg;

  typedef enum logic [2:0] {
    KP_IDLE           = 3'd0,
    KP_PRESS_BOUNCE   = 3'd1,
    KP_HOLD           = 3'd2,
    KP_RELEASE_BOUNCE = 3'd3,
    KP_GAP            = 3'd4
  } kp_state_t;

  // key code = {row[1:0], col[1:0]}
  localparam int KP_ROW_MSB = 3;
  localparam int KP_ROW_LSB = 2;
  localparam int KP_COL_MSB = 1;
  localparam int KP_COL_LSB = 0;

  localparam logic [3:0] KP_IDLE_ROWS = 4'b1111;

  localparam int KP_CLK_HZ = 27_000_000;

  // Active-low one-hot row pattern for a row index.
  function automatic logic [3:0] kp_row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

endpackage

// File: rtl/keypad_press_emulator_if.sv
// keypad_press_emulator_if
// Key-code request handshake between the self-test sequencer (master) and the
// row emulator (slave).
//   code_i  : 4-bit key code {row, col}
//   valid_i : request
//   ready_o : emulator idle; transfer on valid_i && ready_o
interface keypad_press_emulator_if;
  logic [3:0] code_i;
  logic       valid_i;
  logic       ready_o;

  modport master (output code_i, output valid_i, input ready_o);
  modport slave  (input code_i, input valid_i, output ready_o);
endinterface

// File: rtl/keypad_press_emulator_phase_timer.sv
// phase_timer
// Loadable down-counter for the emulator phases, plus a free-running tick
// divider that restarts on every load so bounce toggles align to phase entry.
//   clk, rst   : clock, synchronous active-low reset
//   load_i     : load load_val_i into the counter (and restart the divider)
//   load_val_i : phase length minus one
//   zero_o     : counter is at 0 (last cycle of the phase)
//   tick_o     : high once every PERIOD cycles
module phase_timer #(
  parameter int CNT_W  = 13,
  parameter int PERIOD = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (load_i) begin
      cnt_d = load_val_i;
      div_d = PERIOD_M1;
    end else begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      div_d = (div_q == '0) ? PERIOD_M1 : div_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      div_q <= PERIOD_M1;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign tick_o = (div_q == '0);

endmodule

// File: rtl/keypad_press_emulator.sv
// keypad_press_emulator
// Emulates a physical key on the 4x4 keypad row lines: accepts a key code,
// presses with contact bounce, holds, releases with bounce, then idles for a
// gap before the next code is accepted.
//   clk, rst : 27 MHz clock, synchronous active-low reset
//   req      : code/valid/ready handshake (slave side)
//   col_i    : active-low column scan from the decoder
//   key_o    : active-low row lines (registered) to the decoder
//   busy_o   : key cycle in progress
//   done_o   : one-cycle pulse in the first idle cycle after a key cycle
//
// state           | meaning
// ----------------+---------------------------------------------------------
// IDLE            | ready for a code, contact open
// PRESS_BOUNCE    | contact starts closed, toggles every BOUNCE_PERIOD
// HOLD            | contact closed
// RELEASE_BOUNCE  | contact starts open, toggles every BOUNCE_PERIOD
// GAP             | contact open, next code not yet accepted
module keypad_press_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 8100,
  parameter int BOUNCE_CYCLES = 270,
  parameter int BOUNCE_PERIOD = 27,
  parameter int GAP_CYCLES    = 8100
) (
  input  logic                           clk,
  input  logic                           rst,
  keypad_press_emulator_if.slave         req,
  input  logic [3:0]                     col_i,
  output logic [3:0]                     key_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int MAX_AB  = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int MAX_CD  = (GAP_CYCLES > BOUNCE_PERIOD) ? GAP_CYCLES : BOUNCE_PERIOD;
  localparam int MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  kp_state_t        state_q, state_d;
  logic [3:0]       code_q, code_d;
  logic             contact_q, contact_d;
  logic [3:0]       key_q, key_d;
  logic             done_q, done_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             tmr_tick;

  function automatic int phase_len(input kp_state_t s);
    case (s)
      KP_PRESS_BOUNCE,
      KP_RELEASE_BOUNCE: return BOUNCE_CYCLES;
      KP_HOLD:           return HOLD_CYCLES;
      KP_GAP:            return GAP_CYCLES;
      default:           return 0;
    endcase
  endfunction

  function automatic kp_state_t step(input kp_state_t s);
    case (s)
      KP_IDLE:           return KP_PRESS_BOUNCE;
      KP_PRESS_BOUNCE:   return KP_HOLD;
      KP_HOLD:           return KP_RELEASE_BOUNCE;
      KP_RELEASE_BOUNCE: return KP_GAP;
      default:           return KP_IDLE;
    endcase
  endfunction

  // Following phase, skipping any configured with zero length.
  function automatic kp_state_t next_phase(input kp_state_t s);
    kp_state_t n;
    n = step(s);
    for (int i = 0; i < 4; i++) begin
      if (n != KP_IDLE && phase_len(n) == 0) n = step(n);
    end
    return n;
  endfunction

  // Counter holds length-1 so the phase exits on the cycle it reads zero.
  function automatic logic [CNT_W-1:0] phase_load(input kp_state_t s);
    int len;
    len = phase_len(s);
    return (len > 0) ? CNT_W'(len - 1) : '0;
  endfunction

  phase_timer #(
    .CNT_W  (CNT_W),
    .PERIOD (BOUNCE_PERIOD)
  ) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero),
    .tick_o     (tmr_tick)
  );

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    contact_d = contact_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      KP_IDLE: begin
        if (req.valid_i) begin
          code_d  = req.code_i;
          state_d = next_phase(KP_IDLE);
        end
      end
      default: begin
        if (tmr_zero) begin
          state_d = next_phase(state_q);
        end else if (tmr_tick &&
                     (state_q == KP_PRESS_BOUNCE || state_q == KP_RELEASE_BOUNCE)) begin
          contact_d = ~contact_q;
        end
      end
    endcase

    // Phase entry: reload the timer and force the contact to the phase's
    // starting level, which also pins it closed/open at bounce exit.
    if (state_d != state_q) begin
      tmr_load  = 1'b1;
      tmr_val   = phase_load(state_d);
      contact_d = (state_d == KP_PRESS_BOUNCE) || (state_d == KP_HOLD);
    end

    done_d = (state_q != KP_IDLE) && (state_d == KP_IDLE);

    // Non-one-hot scans are decoded by the latched column bit alone.
    if (contact_q && !col_i[code_q[KP_COL_MSB:KP_COL_LSB]])
      key_d = kp_row_drive(code_q[KP_ROW_MSB:KP_ROW_LSB]);
    else
      key_d = KP_IDLE_ROWS;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= KP_IDLE;
      code_q    <= '0;
      contact_q <= 1'b0;
      key_q     <= KP_IDLE_ROWS;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      contact_q <= contact_d;
      key_q     <= key_d;
      done_q    <= done_d;
    end
  end

  assign req.ready_o = (state_q == KP_IDLE);
  assign busy_o      = (state_q != KP_IDLE);
  assign done_o      = done_q;
  assign key_o       = key_q;

endmodule

// File: tb/tb_keypad_press_emulator.sv
// Bench for keypad_press_emulator: two builds (with and without bounce).
// Stimulus pushes the expected per-key summary into a queue; a monitor
// accumulates what each DUT shows between acceptance and done_o and compares
// against the popped record. Offsets count rising edges from the edge that
// registered the handshake.
module tb_keypad_press_emulator;
  import keypad_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] col_a, col_b, key_a, key_b;
  logic       busy_a, busy_b, done_a, done_b;

  keypad_press_emulator_if if_a ();
  keypad_press_emulator_if if_b ();

  keypad_press_emulator #(
    .HOLD_CYCLES(20), .BOUNCE_CYCLES(6), .BOUNCE_PERIOD(2), .GAP_CYCLES(10)
  ) dut_a (
    .clk(clk), .rst(rst), .req(if_a), .col_i(col_a),
    .key_o(key_a), .busy_o(busy_a), .done_o(done_a)
  );

  keypad_press_emulator #(
    .HOLD_CYCLES(20), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(2), .GAP_CYCLES(10)
  ) dut_b (
    .clk(clk), .rst(rst), .req(if_b), .col_i(col_b),
    .key_o(key_b), .busy_o(busy_b), .done_o(done_b)
  );

  typedef struct {
    int         dut;
    int         lat;
    int         lows;
    int         first_low;
    int         toggles;
    logic [3:0] low_val;
    int         rdy_low;
    bit         b2b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [3:0] m_key[2];
  logic       m_busy[2], m_ready[2], m_done[2];
  always_comb begin
    m_key[0]   = key_a;   m_key[1]   = key_b;
    m_busy[0]  = busy_a;  m_busy[1]  = busy_b;
    m_ready[0] = if_a.ready_o; m_ready[1] = if_b.ready_o;
    m_done[0]  = done_a;  m_done[1]  = done_b;
  end

  // ---------------- monitor / scoreboard ----------------
  int         cyc = 0;
  int         act[2]       = '{0, 0};
  int         acc[2]       = '{0, 0};
  int         lows[2]      = '{0, 0};
  int         first[2]     = '{-1, -1};
  int         tog[2]       = '{0, 0};
  int         rdyl[2]      = '{0, 0};
  int         last_done[2] = '{-100, -100};
  logic [3:0] pkey[2]      = '{4'hf, 4'hf};
  logic [3:0] lowv[2]      = '{4'hf, 4'hf};
  bit         mixed[2]     = '{1'b0, 1'b0};
  bit         pbusy[2]     = '{1'b0, 1'b0};
  exp_t       e;

  always @(posedge clk) begin
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (act[d] != 0) begin
        if (m_key[d] !== pkey[d]) tog[d]++;
        if (m_key[d] !== KP_IDLE_ROWS) begin
          lows[d]++;
          if (first[d] < 0) first[d] = cyc - acc[d];
          if (lowv[d] === KP_IDLE_ROWS) lowv[d] = m_key[d];
          else if (lowv[d] !== m_key[d]) mixed[d] = 1'b1;
        end
        if (m_ready[d] === 1'b0) rdyl[d]++;
        pkey[d] = m_key[d];
      end
      if (m_done[d] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: dut %0d pulsed done_o at cycle %0d with nothing expected", d, cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_dut_id", d, e.dut);
          check("active_at_done", act[d], 1);
          check("latency", cyc - acc[d], e.lat);
          check("low_cycles", lows[d], e.lows);
          check("first_low_offset", first[d], e.first_low);
          check("key_toggles", tog[d], e.toggles);
          check("low_row_value", mixed[d] ? -1 : int'(lowv[d]), int'(e.low_val));
          check("ready_low_cycles", rdyl[d], e.rdy_low);
          check("ready_in_done_cycle", int'(m_ready[d]), 1);
          if (e.b2b) check("b2b_accept_edge", acc[d], last_done[d] + 1);
        end
        last_done[d] = cyc;
        act[d] = 0;
      end else if (!m_busy[d] && pbusy[d]) begin
        act[d] = 0;
      end
      if (m_busy[d] && !pbusy[d]) begin
        act[d]   = 1;
        acc[d]   = cyc;
        lows[d]  = 0;
        first[d] = -1;
        tog[d]   = 0;
        rdyl[d]  = (m_ready[d] === 1'b0) ? 1 : 0;
        pkey[d]  = m_key[d];
        lowv[d]  = KP_IDLE_ROWS;
        mixed[d] = 1'b0;
      end
      pbusy[d] = m_busy[d];
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input int dut, input int lat, input int lw, input int fl,
                      input int tg, input logic [3:0] lv, input int rl, input bit b2b);
    exp_t x;
    x.dut = dut; x.lat = lat; x.lows = lw; x.first_low = fl;
    x.toggles = tg; x.low_val = lv; x.rdy_low = rl; x.b2b = b2b;
    exp_q.push_back(x);
  endtask

  task automatic drive_req(input int d, input logic v, input logic [3:0] c);
    if (d == 0) begin if_a.valid_i = v; if_a.code_i = c; end
    else        begin if_b.valid_i = v; if_b.code_i = c; end
  endtask

  // Returns at the negedge following the acceptance edge (offset 0).
  task automatic send(input int d, input logic [3:0] c);
    int n = 0;
    @(negedge clk);
    while (m_ready[d] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", int'(n < 500), 1);
    drive_req(d, 1'b1, c);
    @(negedge clk);
    drive_req(d, 1'b0, c);
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (m_busy[d] !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", int'(n < 300), 1);
    @(negedge clk);
  endtask

  logic [3:0] rot[4];

  initial begin
    int n;
    rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111;
    rst   = 1'b0;
    col_a = 4'hf;
    col_b = 4'hf;
    drive_req(0, 1'b0, 4'h0);
    drive_req(1, 1'b0, 4'h0);
    repeat (3) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      check("reset_key", int'(m_key[d]), 15);
      check("reset_ready", int'(m_ready[d]), 1);
      check("reset_busy", int'(m_busy[d]), 0);
      check("reset_done", int'(m_done[d]), 0);
    end
    rst = 1'b1;
    @(negedge clk);

    // Row 1 col 2, column held selected: 4 bounce lows + 20 hold + 2 release lows.
    col_a = 4'b1011;
    push(0, 42, 26, 1, 6, 4'b1101, 42, 1'b0);
    send(0, 4'b0110);
    wait_idle(0);

    // Column never selected: rows stay released, done timing unchanged.
    col_a = 4'b1110;
    push(0, 42, 0, -1, 0, 4'b1111, 42, 1'b0);
    send(0, 4'b0110);
    wait_idle(0);

    // Rotating scan from offset 0; col3 selected at offsets 3,7,...;
    // contact closed at 7,11,15,19,23 -> rows low at offsets 8..24 step 4.
    col_a = 4'hf;
    push(0, 42, 5, 8, 10, 4'b0111, 42, 1'b0);
    send(0, 4'b1111);
    for (int k = 0; k < 46; k++) begin
      col_a = rot[k % 4];
      @(negedge clk);
    end
    col_a = 4'b1011;
    @(negedge clk);

    // Back-to-back with valid held; non-one-hot scan 1100 selects both cols 0
    // and 1. code_i changes after the first acceptance must not take effect.
    col_a = 4'b1100;
    push(0, 42, 26, 1, 6, 4'b1110, 42, 1'b0);
    push(0, 42, 26, 1, 6, 4'b1101, 42, 1'b1);
    @(negedge clk);
    drive_req(0, 1'b1, 4'b0000);
    @(negedge clk);
    drive_req(0, 1'b1, 4'b0101);
    n = 0;
    while (m_done[0] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done_seen", int'(n < 200), 1);
    @(negedge clk);
    drive_req(0, 1'b0, 4'b0101);
    wait_idle(0);

    // Reset in HOLD, then immediate re-accept on the first edge after release.
    col_a = 4'b1011;
    send(0, 4'b0110);
    repeat (12) @(negedge clk);
    check("hold_key_before_reset", int'(key_a), int'(4'b1101));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("post_reset_key", int'(key_a), 15);
    check("post_reset_ready", int'(if_a.ready_o), 1);
    check("post_reset_busy", int'(busy_a), 0);
    check("post_reset_done", int'(done_a), 0);
    push(0, 42, 26, 1, 6, 4'b1101, 42, 1'b0);
    drive_req(0, 1'b1, 4'b0110);
    @(negedge clk);
    drive_req(0, 1'b0, 4'b0110);
    check("post_reset_accepted", int'(busy_a), 1);
    wait_idle(0);

    // No-bounce build: straight into HOLD, 20 + 10 cycles.
    col_b = 4'b1011;
    push(1, 30, 20, 1, 2, 4'b1101, 30, 1'b0);
    send(1, 4'b0110);
    wait_idle(1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched so far", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_press_emulator.md
# keypad_press_emulator

Synthesizable transmitter side of the 4x4 keypad row interface. It accepts a key code through a valid/ready handshake and drives the active-low row lines (`key_o`) exactly as a physical key would. Rows respond to the column scan (`col_i`) and include deterministic contact bounce on press and on release. It sits between a loopback/self-test sequencer and the keypad decoder input (`key_in`), so the decoder, debouncer and multiplier path can be exercised on-board without a keypad.

## Interface
- `HOLD_CYCLES`, default 8100: stable-pressed duration in clk cycles (300 µs at 27 MHz).
- `BOUNCE_CYCLES`, default 270: duration of each bounce phase (press and release); 0 disables bounce.
- `BOUNCE_PERIOD`, default 27: cycles between contact toggles inside a bounce phase; must be ≥1.
- `GAP_CYCLES`, default 8100: released idle time before the next key is accepted.

Ports:
- `clk`  in  1  system clock, 27 MHz.
- `rst`  in  1  synchronous, active-low reset.
- `code_i`  in  4  key code; `[3:2]` is the row index, `[1:0]` is the column index.
- `valid_i`  in  1  code request.
- `ready_o`  out  1  emulator idle; a code is accepted when `valid_i && ready_o`.
- `col_i`  in  4  column scan from the decoder, active-low one-hot.
- `key_o`  out  4  row lines, active-low, to the decoder `key_in`.
- `busy_o`  out  1  high from acceptance until return to IDLE.
- `done_o`  out  1  one-cycle pulse when the key cycle completes.

## Operation
- FSM states: IDLE → PRESS_BOUNCE → HOLD → RELEASE_BOUNCE → GAP → IDLE.
- IDLE: `ready_o`=1. On handshake, latch `code_i`, load the phase counter, go to PRESS_BOUNCE. If `BOUNCE_CYCLES`=0, go directly to HOLD.
- `contact` register drives the rows:
  - PRESS_BOUNCE: `contact` starts at 1 and toggles every `BOUNCE_PERIOD` cycles; it is forced to 1 on exit.
  - HOLD: `contact`=1.
  - RELEASE_BOUNCE: `contact` starts at 0 and toggles every `BOUNCE_PERIOD` cycles; it is forced to 0 on exit.
  - GAP and IDLE: `contact`=0.
- Row drive: `key_o` = ~(1 << row) when `contact`=1 and `col_i[col]`=0; otherwise `key_o` = 4'b1111.
- `col_i` that is not one-hot (0 or ≥2 columns low) is decoded by the latched column bit only. No error is flagged.
- The phase counter counts down to 0. A phase of N cycles lasts exactly N cycles; N=0 skips the phase.
- `valid_i` outside IDLE is ignored. `code_i` changes after acceptance have no effect.
- Reset mid-operation: FSM returns to IDLE, the latched code is cleared, and the key is released. The next edge after reset deassertion can already accept a code.

## Timing
- Reset values: `key_o`=4'b1111, `ready_o`=1, `busy_o`=0, `done_o`=0, `contact`=0, state IDLE.
- Handshake at edge T:
  - `ready_o`=0 and `busy_o`=1 from T+1.
  - `contact`=1 from T+1.
  - `key_o` is registered: the first low row appears at T+2 if the column is already selected.
- `key_o` follows `col_i` with 1 cycle of latency.
- Total cycle from acceptance to `done_o`: 2·`BOUNCE_CYCLES` + `HOLD_CYCLES` + `GAP_CYCLES` cycles.
- `done_o` is high in the first IDLE cycle. `ready_o`=1 in the same cycle.
- A back-to-back request (`valid_i` held high) is accepted in that same cycle.
- The counter is `$clog2` of the largest parameter +1 bits wide. Parameters are elaborated once; there is no runtime reconfiguration.

## Structure
- `keypad_pkg` holds:
  - the `kp_state_t` enum;
  - the code field slices `KP_ROW_MSB`/`KP_ROW_LSB`/`KP_COL_MSB`/`KP_COL_LSB`;
  - `KP_IDLE_ROWS` = 4'b1111;
  - the 27 MHz clock constant.
  
  The decoder reuses this package.
- Sub-module `phase_timer`: a loadable down-counter with a `zero` flag and a `BOUNCE_PERIOD` tick output. It is instantiated once. The top level holds the FSM, the `contact` logic and the row encoder.

## Test plan
Parameters for the bench: `HOLD_CYCLES`=20, `BOUNCE_CYCLES`=6, `BOUNCE_PERIOD`=2, `GAP_CYCLES`=10; the decoder column scan is modelled in the bench.

- Code 4'b0110 (row 1, col 2) with `col_i` fixed at 4'b1011:
  - `key_o` toggles 4'b1101/4'b1111 every 2 cycles for 6 cycles, holds 4'b1101 for 20 cycles, bounces 6 cycles, then stays 4'b1111;
  - `done_o` pulses at acceptance+42.
- Same code with `col_i` fixed at 4'b1110: `key_o` stays 4'b1111 for the whole cycle; `done_o` still pulses at +42.
- Rotating `col_i` 1110→1101→1011→0111, one column per cycle, with code 4'b1111: `key_o`=4'b0111 only the cycle after `col_i`=0111, during HOLD.
- `valid_i` held high with codes 4'b0000 then 4'b0101: the second code is accepted in the `done_o` cycle, and `ready_o` is low for exactly 42 cycles per key.
- `rst` asserted low for 1 cycle during HOLD: the next cycle shows `key_o`=4'b1111, `ready_o`=1, `busy_o`=0, and no `done_o` pulse.
- `BOUNCE_CYCLES`=0 build: `key_o` goes low at acceptance+2 with no toggling, and `done_o` pulses at acceptance+30.
